muldiv_iter: RTL and testbench
==============================

Name: muldiv_iter

Overview:
Parametrised iterative multiply/divide unit that succeeds the single-bit serial multiplier inside the execute stage. It handles signed, unsigned and mixed multiply, and signed and unsigned divide. Multiply retires STEP bits per cycle and produces a full 2*RV product as lo/hi halves. Execute issues operands with start, stalls on ready, writes back on done, and can load the hi half directly through the hi register write port.

Parameters:
RV, 32, operand width; must be a multiple of STEP.
STEP, 2, multiplier bits retired per cycle; legal values 1, 2, 4. Divide always retires 1 bit per cycle.

Ports:
clk  in  1  clock
reset  in  1  reset, synchronous, active-low
start  in  1  issue request; accepted only when ready=1
op  in  3  0 MUL unsigned; 1 MULS signed*signed; 2 MULSU signed a * unsigned b; 4 DIVU; 5 DIV signed; 3,6,7 reserved
a  in  RV  multiplicand or dividend, sampled at acceptance
b  in  RV  multiplier or divisor, sampled at acceptance
abort  in  1  cancels an in-flight operation (trap or interrupt)
hi_we  in  1  write result_hi from hi_wdata while idle
hi_wdata  in  RV  data for hi_we
ready  out  1  idle; can accept start
done  out  1  one-cycle completion pulse
result_lo  out  RV  MUL*: product[RV-1:0]; DIV*: quotient
result_hi  out  RV  MUL*: product[2RV-1:RV]; DIV*: remainder
div_by_zero  out  1  valid with done; divisor was 0
op_err  out  1  valid with done; reserved or unsupported op

Behaviour:
- Reset (reset=0): state IDLE. done=0, div_by_zero=0, op_err=0, result_lo=0, result_hi=0. ready=0 while reset is low. start, hi_we and abort are ignored.
- FSM states: IDLE, RUN, FIX.
  - IDLE with start=1 and ready=1: latch operand magnitudes and sign flags, load counter N, go to RUN. N = RV/STEP for multiply, RV for divide.
  - RUN: one iteration per cycle, counter decrements. At count 1 go to FIX.
  - FIX: apply sign negation, write result_lo/result_hi, go to IDLE.
- Timing, with the acceptance edge as edge 0: done is high for exactly one cycle starting at edge N+1. Results and flags update at that same edge. ready is high again in that done cycle, so a back-to-back start is accepted in the done cycle.
- Multiply: MSB-first shift-add on magnitudes. Each cycle the accumulator is shifted left by STEP and adds |b| * (next STEP bits of |a|). Result sign is sa^sb. For MULSU, sb=0. FIX negates the full 2*RV value when the sign is set.
- Divide: restoring, unsigned, on magnitudes.
  - Signed quotient truncates toward zero. Remainder takes the sign of the dividend.
  - Overflow case 0x80000000/0xFFFFFFFF gives quotient 0x80000000, remainder 0.
  - Divisor 0: quotient all ones, remainder = a unchanged (no sign fixup), div_by_zero=1. Latency is unchanged (N+1).
- op_err ops skip RUN and FIX. done asserts at edge 1 with result_lo=result_hi=0 and op_err=1.
- start while ready=0 is ignored; there is no queueing.
- abort while RUN or FIX: return to IDLE at the next edge, no done, result_lo/result_hi keep their previous values. abort in IDLE has no effect. If abort and start are both high in the same cycle, abort wins and start is dropped.
- hi_we is honoured only in IDLE and only without start. It loads result_hi at the next edge. If start and hi_we are both high, start wins.
- result_lo/result_hi are held between operations. div_by_zero and op_err are held until the next done.

Optional Feature:
MULDIV_DIV_EN.
- Defined: DIVU and DIV behave as specified above.
- Undefined: the divider datapath and remainder logic are removed. Ops 4 and 5 are treated as reserved: done at edge 1, op_err=1, results 0. Multiply behaviour and latency are unchanged.

Test Plan:
1. RV=32, STEP=2: MUL a=0xFFFFFFFF, b=0xFFFFFFFF -> done at edge 17, result_lo=0x00000001, result_hi=0xFFFFFFFE, ready=1 in the done cycle.
2. MULS a=0xFFFFFFFD (-3), b=7 -> result_lo=0xFFFFFFEB, result_hi=0xFFFFFFFF. Then MULSU with the same operands -> result_lo=0xFFFFFFEB, result_hi=0xFFFFFFFF.
3. DIV a=0xFFFFFFF9 (-7), b=2 -> done at edge 33, quotient 0xFFFFFFFD, remainder 0xFFFFFFFF. DIV a=0x80000000, b=0xFFFFFFFF -> quotient 0x80000000, remainder 0.
4. DIVU a=5, b=0 -> done at edge 33, quotient 0xFFFFFFFF, remainder 5, div_by_zero=1. Next op clears div_by_zero.
5. MUL started, abort at edge 5 -> no done pulse, ready=1 at edge 6, results unchanged. Then hi_we with 0x1234 in IDLE -> result_hi=0x1234. hi_we raised together with start -> hi_we ignored.
6. op=6, and op=4 built without MULDIV_DIV_EN -> done at edge 1, op_err=1, results 0. Hold reset low during RUN -> all outputs return to reset values.

Source files
------------

// File: rtl/muldiv_iter.sv
// muldiv_iter: iterative multiply (STEP bits/cycle, MSB-first shift-add) and restoring divide (1 bit/cycle).
// The divide datapath is built only when MULDIV_DIV_EN is defined; otherwise ops 4/5 report op_err.
module muldiv_iter #(
    parameter int RV   = 32,
    parameter int STEP = 2
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start_i,
    input  logic [2:0]    op_i,
    input  logic [RV-1:0] a_i,
    input  logic [RV-1:0] b_i,
    input  logic          abort_i,
    input  logic          hi_we_i,
    input  logic [RV-1:0] hi_wdata_i,
    output logic          ready_o,
    output logic          done_o,
    output logic [RV-1:0] result_lo_o,
    output logic [RV-1:0] result_hi_o,
    output logic          div_by_zero_o,
    output logic          op_err_o
);
    localparam int CW   = $clog2(RV + 1);
    localparam int NMUL = RV / STEP;

    localparam logic [2:0] OP_MUL   = 3'd0;
    localparam logic [2:0] OP_MULS  = 3'd1;
    localparam logic [2:0] OP_MULSU = 3'd2;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_DIV   = 3'd5;

    typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

    state_t          state_q;
    logic            ready_q, done_q, div_by_zero_q, op_err_q;
    logic [RV-1:0]   result_lo_q, result_hi_q;
    logic [RV-1:0]   mag_a_q, mag_b_q;
    logic [2*RV-1:0] acc_q;
    logic [CW-1:0]   cnt_q;
    logic            is_div_q, bad_op_q, neg_lo_q, neg_hi_q, b_zero_q;

    // Issue-side decode: operand magnitudes and sign flags
    logic          is_mul, is_div, sign_a, sign_b;
    logic [RV-1:0] mag_a, mag_b;

    always_comb begin
        is_mul = (op_i == OP_MUL) || (op_i == OP_MULS) || (op_i == OP_MULSU);
`ifdef MULDIV_DIV_EN
        is_div = (op_i == OP_DIVU) || (op_i == OP_DIV);
`else
        is_div = 1'b0;
`endif
        sign_a = a_i[RV-1] && ((op_i == OP_MULS) || (op_i == OP_MULSU) || (is_div && op_i == OP_DIV));
        sign_b = b_i[RV-1] && ((op_i == OP_MULS) || (is_div && op_i == OP_DIV));
        mag_a  = sign_a ? -a_i : a_i;
        mag_b  = sign_b ? -b_i : b_i;
    end

    // Multiply step: acc = (acc << STEP) + |b| * next STEP bits of |a|
    logic [STEP-1:0]    digit;
    logic [RV+STEP-1:0] partial;
    logic [2*RV-1:0]    mul_acc_d;

    always_comb begin
        digit   = mag_a_q[RV-1 -: STEP];
        partial = '0;
        for (int i = 0; i < STEP; i++) begin
            if (digit[i]) partial = partial + ({{STEP{1'b0}}, mag_b_q} << i);
        end
        mul_acc_d = (acc_q << STEP) + {{(RV-STEP){1'b0}}, partial};
    end

`ifdef MULDIV_DIV_EN
    // Restoring divide step: remainder in acc_q[RV-1:0], dividend shifts out of mag_a_q
    // while quotient bits shift in from the bottom.
    logic [RV:0]     r_sh, diff;
    logic [2*RV-1:0] div_acc_d;
    logic [RV-1:0]   div_quo_d;

    always_comb begin
        r_sh      = {acc_q[RV-1:0], mag_a_q[RV-1]};
        diff      = r_sh - {1'b0, mag_b_q};
        div_acc_d = {{RV{1'b0}}, (diff[RV] ? r_sh[RV-1:0] : diff[RV-1:0])};
        div_quo_d = {mag_a_q[RV-2:0], ~diff[RV]};
    end
`endif

    // Sign fixup; a zero divisor leaves |a| in the remainder, so the dividend-sign
    // negation hands back a unchanged.
    logic [2*RV-1:0] prod_fix;
    logic [RV-1:0]   quo_fix, rem_fix;

    always_comb begin
        prod_fix = neg_lo_q ? -acc_q : acc_q;
        quo_fix  = b_zero_q ? '1 : (neg_lo_q ? -mag_a_q : mag_a_q);
        rem_fix  = neg_hi_q ? -acc_q[RV-1:0] : acc_q[RV-1:0];
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q       <= IDLE;
            ready_q       <= 1'b0;
            done_q        <= 1'b0;
            div_by_zero_q <= 1'b0;
            op_err_q      <= 1'b0;
            result_lo_q   <= '0;
            result_hi_q   <= '0;
            mag_a_q       <= '0;
            mag_b_q       <= '0;
            acc_q         <= '0;
            cnt_q         <= '0;
            is_div_q      <= 1'b0;
            bad_op_q      <= 1'b0;
            neg_lo_q      <= 1'b0;
            neg_hi_q      <= 1'b0;
            b_zero_q      <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    ready_q <= 1'b1;
                    if (start_i && ready_q && !abort_i) begin
                        ready_q  <= 1'b0;
                        is_div_q <= is_div;
                        bad_op_q <= !(is_mul || is_div);
                        mag_a_q  <= mag_a;
                        mag_b_q  <= mag_b;
                        acc_q    <= '0;
                        neg_lo_q <= sign_a ^ sign_b;
                        neg_hi_q <= is_div ? sign_a : (sign_a ^ sign_b);
                        b_zero_q <= is_div && (b_i == '0);
                        cnt_q    <= is_div ? CW'(RV) : CW'(NMUL);
                        // Reserved ops take the single FIX cycle so done lands one edge after issue
                        state_q  <= (is_mul || is_div) ? RUN : FIX;
                    end else if (hi_we_i && ready_q && !start_i) begin
                        result_hi_q <= hi_wdata_i;
                    end
                end
                RUN: begin
                    if (abort_i) begin
                        state_q <= IDLE;
                        ready_q <= 1'b1;
                    end else begin
`ifdef MULDIV_DIV_EN
                        if (is_div_q) begin
                            acc_q   <= div_acc_d;
                            mag_a_q <= div_quo_d;
                        end else
`endif
                        begin
                            acc_q   <= mul_acc_d;
                            mag_a_q <= mag_a_q << STEP;
                        end
                        cnt_q <= cnt_q - CW'(1);
                        if (cnt_q == CW'(1)) state_q <= FIX;
                    end
                end
                FIX: begin
                    state_q <= IDLE;
                    ready_q <= 1'b1;
                    if (!abort_i) begin
                        done_q        <= 1'b1;
                        op_err_q      <= bad_op_q;
                        div_by_zero_q <= b_zero_q;
                        if (bad_op_q) begin
                            result_lo_q <= '0;
                            result_hi_q <= '0;
                        end else if (is_div_q) begin
                            result_lo_q <= quo_fix;
                            result_hi_q <= rem_fix;
                        end else begin
                            result_lo_q <= prod_fix[RV-1:0];
                            result_hi_q <= prod_fix[2*RV-1:RV];
                        end
                    end
                end
                default: begin
                    state_q <= IDLE;
                    ready_q <= 1'b0;
                end
            endcase
        end
    end

    assign ready_o       = ready_q;
    assign done_o        = done_q;
    assign result_lo_o   = result_lo_q;
    assign result_hi_o   = result_hi_q;
    assign div_by_zero_o = div_by_zero_q;
    assign op_err_o      = op_err_q;

endmodule

// File: tb/tb_muldiv_iter.sv
// Bench for muldiv_iter (RV=32, STEP=2): directed scenarios plus randomized ops against a plain-arithmetic model.
// Expectations for ops 4/5 follow MULDIV_DIV_EN, matching the RTL build.
module tb_muldiv_iter;
    logic        clk = 1'b0, reset = 1'b0, start = 1'b0, abort = 1'b0, hi_we = 1'b0;
    logic [2:0]  op = 3'd0;
    logic [31:0] a = '0, b = '0, hi_wdata = '0;
    logic        ready, done, dz, err;
    logic [31:0] lo, hi;
    int checks = 0, errors = 0;

    always #5 clk = ~clk;

    muldiv_iter #(.RV(32), .STEP(2)) dut (
        .clk(clk), .reset(reset), .start_i(start), .op_i(op), .a_i(a), .b_i(b),
        .abort_i(abort), .hi_we_i(hi_we), .hi_wdata_i(hi_wdata),
        .ready_o(ready), .done_o(done), .result_lo_o(lo), .result_hi_o(hi),
        .div_by_zero_o(dz), .op_err_o(err)
    );

    function automatic void model(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                                  output logic [31:0] lo_e, output logic [31:0] hi_e,
                                  output logic dz_e, output logic err_e, output int lat_e);
        logic [63:0] p;
        longint sx, sy;
        int ix, iy;
        lo_e = '0; hi_e = '0; dz_e = 1'b0; err_e = 1'b1; lat_e = 1; p = '0;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        case (o)
            3'd0: p = {32'd0, x} * {32'd0, y};
            3'd1: p = sx * sy;
            3'd2: p = sx * longint'({32'd0, y});
            default: ;
        endcase
        if (o <= 3'd2) begin err_e = 1'b0; lat_e = 17; {hi_e, lo_e} = p; end
`ifdef MULDIV_DIV_EN
        if (o == 3'd4 || o == 3'd5) begin
            err_e = 1'b0; lat_e = 33;
            if (y == 0) begin lo_e = '1; hi_e = x; dz_e = 1'b1; end
            else if (o == 3'd4) begin lo_e = x / y; hi_e = x % y; end
            else if (x == 32'h80000000 && y == 32'hFFFFFFFF) begin lo_e = x; hi_e = '0; end
            else begin ix = x; iy = y; lo_e = ix / iy; hi_e = ix % iy; end
        end
`endif
    endfunction

    // Issue one op at the current cycle (caller guarantees ready), then count edges until done.
    task automatic run_op(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                          output int lat, output logic rdy);
        start = 1'b1; op = o; a = x; b = y;
        @(posedge clk); #1;
        start = 1'b0;
        lat = -1; rdy = 1'b0;
        for (int k = 1; k <= 80; k++) begin
            @(posedge clk); #1;
            if (done) begin lat = k; rdy = ready; break; end
        end
    endtask

    task automatic test_reset();
        reset = 1'b0; start = 1'b1; hi_we = 1'b1; hi_wdata = 32'hFFFF; abort = 1'b1; a = 5; b = 5;
        repeat (3) begin @(posedge clk); #1; end
        checks++;
        if ({ready, done, dz, err, lo, hi} !== 68'h0) begin
            errors++;
            $display("FAIL reset_outputs got rdy=%b done=%b dz=%b err=%b lo=%h hi=%h, want all zero", ready, done, dz, err, lo, hi);
        end
        start = 1'b0; hi_we = 1'b0; abort = 1'b0; reset = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (ready !== 1'b1 || done !== 1'b0) begin
            errors++; $display("FAIL reset_release got rdy=%b done=%b want rdy=1 done=0", ready, done);
        end
    endtask

    task automatic test_mul();
        int lat; logic rdy;
        run_op(3'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, lat, rdy);
        checks++;
        if (lat !== 17 || rdy !== 1'b1) begin errors++; $display("FAIL mul_timing got lat=%0d rdy=%b want 17/1", lat, rdy); end
        checks++;
        if (lo !== 32'h00000001 || hi !== 32'hFFFFFFFE || err !== 1'b0 || dz !== 1'b0) begin
            errors++; $display("FAIL mul_ones got %h_%h err=%b dz=%b want fffffffe_00000001", hi, lo, err, dz);
        end
        @(posedge clk); #1;
        checks++;
        if (done !== 1'b0) begin errors++; $display("FAIL done_pulse got done=%b one cycle later want 0", done); end
        run_op(3'd1, 32'hFFFFFFFD, 32'd7, lat, rdy);
        checks++;
        if (lo !== 32'hFFFFFFEB || hi !== 32'hFFFFFFFF) begin errors++; $display("FAIL muls got %h_%h want ffffffff_ffffffeb", hi, lo); end
        run_op(3'd2, 32'hFFFFFFFD, 32'd7, lat, rdy);
        checks++;
        if (lo !== 32'hFFFFFFEB || hi !== 32'hFFFFFFFF || lat !== 17) begin
            errors++; $display("FAIL mulsu got %h_%h lat=%0d want ffffffff_ffffffeb lat=17", hi, lo, lat);
        end
    endtask

    task automatic test_div();
        int lat, e_lat; logic rdy, e_err; logic [31:0] e_lo, e_hi, e_lo2, e_hi2;
`ifdef MULDIV_DIV_EN
        e_lat = 33; e_err = 1'b0; e_lo = 32'hFFFFFFFD; e_hi = 32'hFFFFFFFF; e_lo2 = 32'h80000000; e_hi2 = 32'h0;
`else
        e_lat = 1; e_err = 1'b1; e_lo = 32'h0; e_hi = 32'h0; e_lo2 = 32'h0; e_hi2 = 32'h0;
`endif
        run_op(3'd5, 32'hFFFFFFF9, 32'd2, lat, rdy);
        checks++;
        if (lat !== e_lat || lo !== e_lo || hi !== e_hi || err !== e_err || rdy !== 1'b1) begin
            errors++; $display("FAIL div_neg7 got lat=%0d q=%h r=%h err=%b want lat=%0d q=%h r=%h err=%b", lat, lo, hi, err, e_lat, e_lo, e_hi, e_err);
        end
        run_op(3'd5, 32'h80000000, 32'hFFFFFFFF, lat, rdy);
        checks++;
        if (lo !== e_lo2 || hi !== e_hi2 || err !== e_err) begin
            errors++; $display("FAIL div_ovf got q=%h r=%h err=%b want q=%h r=%h", lo, hi, err, e_lo2, e_hi2);
        end
    endtask

    task automatic test_divzero();
        int lat, e_lat; logic rdy, e_dz, e_err; logic [31:0] e_lo, e_hi;
`ifdef MULDIV_DIV_EN
        e_lat = 33; e_dz = 1'b1; e_err = 1'b0; e_lo = 32'hFFFFFFFF; e_hi = 32'd5;
`else
        e_lat = 1; e_dz = 1'b0; e_err = 1'b1; e_lo = 32'h0; e_hi = 32'h0;
`endif
        run_op(3'd4, 32'd5, 32'd0, lat, rdy);
        checks++;
        if (lat !== e_lat || lo !== e_lo || hi !== e_hi || dz !== e_dz || err !== e_err) begin
            errors++; $display("FAIL divzero got lat=%0d q=%h r=%h dz=%b err=%b want lat=%0d q=%h r=%h dz=%b", lat, lo, hi, dz, err, e_lat, e_lo, e_hi, e_dz);
        end
        run_op(3'd0, 32'd3, 32'd5, lat, rdy);
        checks++;
        if (dz !== 1'b0 || err !== 1'b0 || lo !== 32'd15 || hi !== 32'd0) begin
            errors++; $display("FAIL dz_clear got dz=%b err=%b lo=%h hi=%h want dz=0 err=0 lo=f hi=0", dz, err, lo, hi);
        end
    endtask

    // Entered with results lo=15, hi=0 from test_divzero.
    task automatic test_abort();
        int seen = 0;
        start = 1'b1; op = 3'd0; a = 32'hFFFFFFFF; b = 32'h12345678;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (5) begin @(posedge clk); #1; end
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        checks++;
        if (ready !== 1'b1) begin errors++; $display("FAIL abort_ready got rdy=%b want 1", ready); end
        for (int k = 0; k < 30; k++) begin
            if (done) seen++;
            @(posedge clk); #1;
        end
        checks++;
        if (seen != 0 || lo !== 32'd15 || hi !== 32'd0) begin
            errors++; $display("FAIL abort_nodone got done_cycles=%0d lo=%h hi=%h want 0, f, 0", seen, lo, hi);
        end
        start = 1'b1; abort = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; abort = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (ready !== 1'b1 || done !== 1'b0) begin
            errors++; $display("FAIL abort_wins got rdy=%b done=%b want rdy=1 done=0", ready, done);
        end
    endtask

    task automatic test_hi_we();
        int lat = -1;
        hi_we = 1'b1; hi_wdata = 32'h1234;
        @(posedge clk); #1;
        hi_we = 1'b0;
        checks++;
        if (hi !== 32'h1234 || lo !== 32'd15) begin errors++; $display("FAIL hi_we got hi=%h lo=%h want 1234/f", hi, lo); end
        start = 1'b1; hi_we = 1'b1; hi_wdata = 32'hDEAD; op = 3'd0; a = 32'd2; b = 32'd3;
        @(posedge clk); #1;
        start = 1'b0; hi_we = 1'b0;
        checks++;
        if (hi !== 32'h1234 || ready !== 1'b0) begin
            errors++; $display("FAIL hi_we_start got hi=%h rdy=%b want 1234/0", hi, ready);
        end
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk); #1;
            if (done) begin lat = k; break; end
        end
        checks++;
        if (lat !== 17 || lo !== 32'd6 || hi !== 32'd0) begin
            errors++; $display("FAIL hi_we_mul got lat=%0d lo=%h hi=%h want 17/6/0", lat, lo, hi);
        end
    endtask

    task automatic test_op_err();
        int lat, e_lat; logic rdy, e_err; logic [31:0] e_lo, e_hi;
        logic [2:0] bad [3] = '{3'd3, 3'd6, 3'd7};
        for (int i = 0; i < 3; i++) begin
            run_op(bad[i], 32'hAAAA5555, 32'h1111, lat, rdy);
            checks++;
            if (lat !== 1 || err !== 1'b1 || lo !== 32'd0 || hi !== 32'd0 || dz !== 1'b0 || rdy !== 1'b1) begin
                errors++; $display("FAIL op_err op=%0d got lat=%0d err=%b lo=%h hi=%h dz=%b rdy=%b want 1/1/0/0/0/1", bad[i], lat, err, lo, hi, dz, rdy);
            end
        end
`ifdef MULDIV_DIV_EN
        e_lat = 33; e_err = 1'b0; e_lo = 32'd14; e_hi = 32'd2;
`else
        e_lat = 1; e_err = 1'b1; e_lo = 32'd0; e_hi = 32'd0;
`endif
        run_op(3'd4, 32'd100, 32'd7, lat, rdy);
        checks++;
        if (lat !== e_lat || err !== e_err || lo !== e_lo || hi !== e_hi) begin
            errors++; $display("FAIL op4_build got lat=%0d err=%b lo=%h hi=%h want %0d/%b/%h/%h", lat, err, lo, hi, e_lat, e_err, e_lo, e_hi);
        end
    endtask

    task automatic test_back_to_back();
        int lat1, lat2, lat3; logic r1, r2, r3;
        run_op(3'd0, 32'd1000, 32'd1000, lat1, r1);
        run_op(3'd1, 32'hFFFFFFFE, 32'hFFFFFFFD, lat2, r2);
        checks++;
        if (lat1 !== 17 || r1 !== 1'b1 || lat2 !== 17 || lo !== 32'd6 || hi !== 32'd0) begin
            errors++; $display("FAIL b2b_mul got lat=%0d/%0d rdy=%b lo=%h hi=%h want 17/17/1/6/0", lat1, lat2, r1, lo, hi);
        end
        run_op(3'd6, 32'd1, 32'd1, lat2, r2);
        run_op(3'd0, 32'h10000, 32'h10000, lat3, r3);
        checks++;
        if (lat2 !== 1 || r2 !== 1'b1 || lat3 !== 17 || lo !== 32'd0 || hi !== 32'd1 || err !== 1'b0) begin
            errors++; $display("FAIL b2b_err got lat=%0d/%0d lo=%h hi=%h err=%b want 1/17/0/1/0", lat2, lat3, lo, hi, err);
        end
    endtask

    function automatic logic [31:0] rnd_operand();
        case ($urandom_range(0, 3))
            0: return $urandom;
            1: return 32'($urandom_range(0, 15));
            2: case ($urandom_range(0, 3))
                   0: return 32'h0;
                   1: return 32'hFFFFFFFF;
                   2: return 32'h80000000;
                   default: return 32'h7FFFFFFF;
               endcase
            default: return -32'($urandom_range(1, 15));
        endcase
    endfunction

    task automatic test_random();
        int lat, e_lat; logic rdy, e_dz, e_err; logic [31:0] x, y, e_lo, e_hi; logic [2:0] o;
        for (int n = 0; n < 40; n++) begin
            case ($urandom_range(0, 11))
                0, 1: o = 3'd0;
                2, 3: o = 3'd1;
                4, 5: o = 3'd2;
                6, 7: o = 3'd4;
                8, 9: o = 3'd5;
                10: o = 3'd3;
                default: o = 3'd7;
            endcase
            x = rnd_operand();
            y = rnd_operand();
            model(o, x, y, e_lo, e_hi, e_dz, e_err, e_lat);
            run_op(o, x, y, lat, rdy);
            checks++;
            if (lat !== e_lat || rdy !== 1'b1) begin
                errors++; $display("FAIL rand_lat op=%0d a=%h b=%h got lat=%0d rdy=%b want %0d/1", o, x, y, lat, rdy, e_lat);
            end
            checks++;
            if (lo !== e_lo || hi !== e_hi || dz !== e_dz || err !== e_err) begin
                errors++; $display("FAIL rand_res op=%0d a=%h b=%h got lo=%h hi=%h dz=%b err=%b want lo=%h hi=%h dz=%b err=%b",
                                   o, x, y, lo, hi, dz, err, e_lo, e_hi, e_dz, e_err);
            end
        end
    endtask

    task automatic test_reset_midrun();
        start = 1'b1; op = 3'd1; a = 32'h7FFFFFFF; b = 32'h7FFFFFFF;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (5) begin @(posedge clk); #1; end
        reset = 1'b0;
        @(posedge clk); #1;
        checks++;
        if ({ready, done, dz, err, lo, hi} !== 68'h0) begin
            errors++; $display("FAIL reset_midrun got rdy=%b done=%b dz=%b err=%b lo=%h hi=%h want all zero", ready, done, dz, err, lo, hi);
        end
        reset = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (ready !== 1'b1 || done !== 1'b0) begin errors++; $display("FAIL reset_recover got rdy=%b done=%b want 1/0", ready, done); end
    endtask

    initial begin
        test_reset();
        test_mul();
        test_div();
        test_divzero();
        test_abort();
        test_hi_we();
        test_op_err();
        test_back_to_back();
        test_random();
        test_reset_midrun();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
